quad_encoder_gen: RTL and testbench
===================================

Name: quad_encoder_gen

Overview:
Quadrature encoder emulator, the transmit side of the incremental-encoder counting path. Accepts up/down step requests in the same updown[1:0] encoding the counters consume and emits a rate-limited A/B quadrature pair. Intended for the test rig and simulation, driving the decoder/counter chain with known motion. Also keeps a wrap-around position count so the bench can compare it with the counter under test.

Parameters:
bits, 8, width of pos, the position counter; wraps modulo 2^bits.
pbits, 8, width of pending, the signed step backlog; two's complement, saturating.
dbits, 16, width of the period input and the internal divider.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
updown  input  2  step request; bit 1 = up, bit 0 = down; 2'b11 and 2'b00 = no request.
en  input  1  edge emission enable; requests still accumulate when low.
period  input  dbits  minimum spacing between edges = period+1 clocks.
clr_ovf  input  1  clears the overflow flag.
q  output  2  quadrature pair, registered; q[1] = A, q[0] = B.
pos  output  bits  emitted-edge position, registered.
pending  output  pbits  signed backlog of steps not yet emitted.
busy  output  1  pending != 0, combinational from the pending register.
overflow  output  1  sticky flag: a request was lost to saturation.
index  output  1  index marker; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clk edge): q=00, pos=0, pending=0, phase=0, div_cnt=0, overflow=0. Reset overrides every other input and aborts any emission in progress.
- Phase sequence for up: 0 -> q=00, 1 -> q=10, 2 -> q=11, 3 -> q=01, then back to 0. Down walks the sequence in reverse. Exactly one of A/B changes per edge.
- Edge condition, evaluated on registered values: en=1, div_cnt=0 and pending!=0.
  - On an edge: phase steps one position in the direction of sign(pending).
  - pos is incremented or decremented with wrap (0 -> 2^bits-1 on down).
  - div_cnt is reloaded with period.
- Otherwise, if div_cnt!=0, div_cnt decrements. If en=0, div_cnt holds.
- q and pos update on the same clock as phase.
- pending update: next = pending + req - emit.
  - req is +1 (updown=10), -1 (01), or 0.
  - emit is +1 or -1 (the edge direction), or 0 when no edge fires.
  - Request and edge on the same cycle are both applied, e.g. pending=1, up request and up edge -> pending stays 1.
- Saturation: the result is clamped to [-(2^(pbits-1)), 2^(pbits-1)-1]. When clamping drops a request, overflow is set on the next clock.
- overflow clears only on clr_ovf=1. If a set and clr_ovf occur on the same cycle, set wins.
- Latency: request sampled at edge n -> pending updated at n+1 -> q/pos updated at n+2, provided div_cnt=0 and en=1.
- With period=0 an edge can fire every clock while pending!=0.
- period changes take effect at the next reload; the running div_cnt is not affected.
- Reversal: a pending sign change is never emitted as a skipped phase; only single-step Gray transitions occur.

Optional Feature:
Macro: QUAD_ENCODER_GEN_INDEX_EN.
- Defined: index is a registered output equal to 1 whenever the registered pos == 0. It updates on the same clock as q and pos, and is 1 out of reset.
- Undefined: index is tied to 0, no extra logic is built, and the port list is unchanged.

Test Plan:
1. Reset; period=0, en=1, one-cycle updown=10 -> two clocks later q=10, pos=1, pending=0, busy low.
2. period=3; four up requests on consecutive clocks -> q steps 10, 11, 01, 00, edges 4 clocks apart, final pos=4, pending=0.
3. From reset, one down request (bits=8) -> q=01, pos=255. A following up request -> q=00, pos=0 (index=1 if enabled).
4. pbits=4, en=0, nine up requests -> pending=7, overflow=1. Then clr_ovf=1 for one clock -> overflow=0. Then en=1 -> seven edges, pos=7.
5. pending=1 with div_cnt=0 and updown=10 on the same clock -> edge emitted, pending remains 1, a second edge follows after period+1 clocks. updown=11 at any time -> pending unchanged.
6. rst pulsed mid-burst (pending=5, q=11) -> next clock q=00, pos=0, pending=0, overflow=0, and no edge on that clock.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature encoder emulator.
// Accepts up/down step requests, keeps a signed saturating backlog and
// emits rate-limited single-step Gray transitions on q = {A, B}.
// Optional index marker is built when QUAD_ENCODER_GEN_INDEX_EN is defined.
module quad_encoder_gen #(
    parameter int bits  = 8,
    parameter int pbits = 8,
    parameter int dbits = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        updown,
    input  logic              en,
    input  logic [dbits-1:0]  period,
    input  logic              clr_ovf,
    output logic [1:0]        q,
    output logic [bits-1:0]   pos,
    output logic [pbits-1:0]  pending,
    output logic              busy,
    output logic              overflow,
    output logic              index
);

    // Saturation bounds, computed two bits wider than the backlog so that
    // pending + req - emit can never wrap before it is clamped.
    localparam logic signed [pbits+1:0] pmax_c = {3'b000, {(pbits-1){1'b1}}};
    localparam logic signed [pbits+1:0] pmin_c = {3'b111, {(pbits-1){1'b0}}};

    // Phase to {A, B}: 0 -> 00, 1 -> 10, 2 -> 11, 3 -> 01.
    function automatic logic [1:0] phase_to_q(input logic [1:0] ph);
        logic [1:0] r;
        case (ph)
            2'd0:    r = 2'b00;
            2'd1:    r = 2'b10;
            2'd2:    r = 2'b11;
            2'd3:    r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    logic [1:0]              phase_r;
    logic [1:0]              q_r;
    logic [bits-1:0]         pos_r;
    logic [pbits-1:0]        pending_r;
    logic [dbits-1:0]        div_cnt_r;
    logic                    overflow_r;

    logic                    edge_s;
    logic                    dir_up_s;
    logic [1:0]              phase_next_s;
    logic [bits-1:0]         pos_next_s;
    logic signed [pbits+1:0] pend_ext_s;
    logic signed [pbits+1:0] req_ext_s;
    logic signed [pbits+1:0] emit_ext_s;
    logic signed [pbits+1:0] sum_s;
    logic [pbits-1:0]        pending_next_s;
    logic                    clamp_s;

    // Edge decision and next-state arithmetic from registered values.
    always_comb begin
        edge_s       = 1'b0;
        dir_up_s     = ~pending_r[pbits-1];
        phase_next_s = phase_r;
        pos_next_s   = pos_r;
        req_ext_s    = '0;
        emit_ext_s   = '0;
        clamp_s      = 1'b0;
        pend_ext_s   = {{2{pending_r[pbits-1]}}, pending_r};

        if (en && (div_cnt_r == {dbits{1'b0}}) && (pending_r != {pbits{1'b0}})) begin
            edge_s = 1'b1;
        end else begin
            edge_s = 1'b0;
        end

        case (updown)
            2'b10:   req_ext_s = {{(pbits+1){1'b0}}, 1'b1};
            2'b01:   req_ext_s = {(pbits+2){1'b1}};
            default: req_ext_s = '0;
        endcase

        if (edge_s) begin
            if (dir_up_s) begin
                emit_ext_s   = {{(pbits+1){1'b0}}, 1'b1};
                phase_next_s = phase_r + 2'd1;
                pos_next_s   = pos_r + {{(bits-1){1'b0}}, 1'b1};
            end else begin
                emit_ext_s   = {(pbits+2){1'b1}};
                phase_next_s = phase_r - 2'd1;
                pos_next_s   = pos_r - {{(bits-1){1'b0}}, 1'b1};
            end
        end else begin
            emit_ext_s = '0;
        end

        sum_s = pend_ext_s + req_ext_s - emit_ext_s;

        // Emission always moves the backlog toward zero, so a clamp can only
        // ever be caused by a request that did not fit.
        if (sum_s > pmax_c) begin
            pending_next_s = pmax_c[pbits-1:0];
            clamp_s        = 1'b1;
        end else if (sum_s < pmin_c) begin
            pending_next_s = pmin_c[pbits-1:0];
            clamp_s        = 1'b1;
        end else begin
            pending_next_s = sum_s[pbits-1:0];
            clamp_s        = 1'b0;
        end
    end

    // Phase, outputs, backlog, divider and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r    <= 2'd0;
            q_r        <= 2'b00;
            pos_r      <= '0;
            pending_r  <= '0;
            div_cnt_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            phase_r   <= phase_next_s;
            q_r       <= phase_to_q(phase_next_s);
            pos_r     <= pos_next_s;
            pending_r <= pending_next_s;

            if (edge_s) begin
                div_cnt_r <= period;
            end else if (en && (div_cnt_r != {dbits{1'b0}})) begin
                div_cnt_r <= div_cnt_r - {{(dbits-1){1'b0}}, 1'b1};
            end else begin
                div_cnt_r <= div_cnt_r;
            end

            // A lost request beats a simultaneous clear.
            if (clamp_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

`ifdef QUAD_ENCODER_GEN_INDEX_EN
    logic index_r;

    // Index marker follows the position register to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_r <= 1'b1;
        end else begin
            index_r <= (pos_next_s == {bits{1'b0}});
        end
    end

    assign index = index_r;
`else
    assign index = 1'b0;
`endif

    assign q        = q_r;
    assign pos      = pos_r;
    assign pending  = pending_r;
    assign busy     = (pending_r != {pbits{1'b0}});
    assign overflow = overflow_r;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed testbench for quad_encoder_gen (bits=8, pbits=4, dbits=16).
module tb_quad_encoder_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  updown;
    logic        en;
    logic [15:0] period;
    logic        clr_ovf;
    logic [1:0]  q;
    logic [7:0]  pos;
    logic [3:0]  pending;
    logic        busy;
    logic        overflow;
    logic        index;

    int tests = 0;
    int fails = 0;

    quad_encoder_gen #(.bits(8), .pbits(4), .dbits(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .updown   (updown),
        .en       (en),
        .period   (period),
        .clr_ovf  (clr_ovf),
        .q        (q),
        .pos      (pos),
        .pending  (pending),
        .busy     (busy),
        .overflow (overflow),
        .index    (index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; updown = 2'b00; en = 1'b1; period = 16'd0; clr_ovf = 1'b0;
        #1;

        // 1: reset state and a single up step at period 0
        do_reset();
        check("rst_q", q, 2'b00);
        check("rst_pos", pos, 8'd0);
        check("rst_pending", pending, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
`ifdef QUAD_ENCODER_GEN_INDEX_EN
        check("rst_index", index, 1'b1);
`else
        check("rst_index", index, 1'b0);
`endif
        updown = 2'b10;
        tick();
        updown = 2'b00;
        check("t1_pending1", pending, 4'd1);
        check("t1_busy1", busy, 1'b1);
        check("t1_q_hold", q, 2'b00);
        tick();
        check("t1_q", q, 2'b10);
        check("t1_pos", pos, 8'd1);
        check("t1_pending0", pending, 4'd0);
        check("t1_busy0", busy, 1'b0);

        // 2: period 3, four up requests, edges four clocks apart
        do_reset();
        period = 16'd3;
        updown = 2'b10;
        tick();
        tick();
        check("t2_e1_q", q, 2'b10);
        check("t2_e1_pos", pos, 8'd1);
        ticks(2);
        updown = 2'b00;
        check("t2_pend3", pending, 4'd3);
        tick();
        check("t2_gap_q", q, 2'b10);
        tick();
        check("t2_e2_q", q, 2'b11);
        ticks(3);
        check("t2_gap2_q", q, 2'b11);
        tick();
        check("t2_e3_q", q, 2'b01);
        ticks(4);
        check("t2_e4_q", q, 2'b00);
        check("t2_pos", pos, 8'd4);
        check("t2_pending", pending, 4'd0);
        check("t2_busy", busy, 1'b0);

        // 3: down wraps position, up returns to zero
        do_reset();
        period = 16'd0;
        updown = 2'b01;
        tick();
        updown = 2'b00;
        check("t3_pend_neg", pending, 4'hF);
        tick();
        check("t3_q_dn", q, 2'b01);
        check("t3_pos_dn", pos, 8'd255);
`ifdef QUAD_ENCODER_GEN_INDEX_EN
        check("t3_index_dn", index, 1'b0);
`endif
        updown = 2'b10;
        tick();
        updown = 2'b00;
        tick();
        check("t3_q_up", q, 2'b00);
        check("t3_pos_up", pos, 8'd0);
`ifdef QUAD_ENCODER_GEN_INDEX_EN
        check("t3_index_up", index, 1'b1);
`endif

        // 4: saturation, overflow clear, draining the backlog
        do_reset();
        en = 1'b0;
        updown = 2'b10;
        ticks(7);
        check("t4_pend7", pending, 4'd7);
        check("t4_no_ovf", overflow, 1'b0);
        ticks(2);
        updown = 2'b00;
        check("t4_pend_sat", pending, 4'd7);
        check("t4_ovf", overflow, 1'b1);
        check("t4_pos_hold", pos, 8'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t4_ovf_clr", overflow, 1'b0);
        en = 1'b1;
        ticks(7);
        check("t4_pos7", pos, 8'd7);
        check("t4_q7", q, 2'b01);
        check("t4_pend0", pending, 4'd0);

        // 5: request and edge on the same clock, then updown=11
        do_reset();
        period = 16'd2;
        updown = 2'b10;
        tick();
        check("t5_pend1", pending, 4'd1);
        tick();
        updown = 2'b00;
        check("t5_e1_q", q, 2'b10);
        check("t5_pend_keep", pending, 4'd1);
        ticks(2);
        check("t5_gap_q", q, 2'b10);
        tick();
        check("t5_e2_q", q, 2'b11);
        check("t5_e2_pos", pos, 8'd2);
        check("t5_pend0", pending, 4'd0);
        updown = 2'b11;
        tick();
        check("t5_upd11", pending, 4'd0);
        updown = 2'b00;

        // 6: reset in the middle of a burst
        do_reset();
        period = 16'd0;
        en = 1'b0;
        updown = 2'b10;
        ticks(8);
        updown = 2'b00;
        en = 1'b1;
        ticks(2);
        check("t6_pre_q", q, 2'b11);
        check("t6_pre_pend", pending, 4'd5);
        check("t6_pre_ovf", overflow, 1'b1);
        rst = 1'b1;
        updown = 2'b10;
        tick();
        rst = 1'b0;
        updown = 2'b00;
        check("t6_q", q, 2'b00);
        check("t6_pos", pos, 8'd0);
        check("t6_pending", pending, 4'd0);
        check("t6_ovf", overflow, 1'b0);
        tick();
        check("t6_q_quiet", q, 2'b00);
        check("t6_pend_quiet", pending, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
